// File: rtl/bs_pkg.sv
// Shared definitions for the bitstream shifter family: length/count types and
// a sign-extension helper sized for the widest supported word.
package bs_pkg;

   localparam int MAX_W     = 64;
   localparam int IDX_W     = $clog2(MAX_W);
   localparam int LEN_W_MAX = $clog2(MAX_W) + 1;
   localparam int CNT_W_MAX = $clog2(2 * MAX_W) + 1;

   typedef logic [LEN_W_MAX-1:0] len_t;
   typedef logic [CNT_W_MAX-1:0] cnt_t;

   // Keeps x[len-1:0] and fills everything above with x[len-1]; len=0 gives 0.
   function automatic logic [MAX_W-1:0] sext(input logic [MAX_W-1:0] x, input len_t len);
      logic [MAX_W-1:0] keep;
      logic [IDX_W-1:0] msb;
      keep = ~({MAX_W{1'b1}} << len);
      msb  = IDX_W'(len - len_t'(1));
      if (len == '0) return '0;
      return (x & keep) | (x[msb] ? ~keep : '0);
   endfunction

endpackage

// File: rtl/bs.sv
// Combinational barrel shifter: left/right, logical/arithmetic, or rotate.
module bs #(
   parameter  int W    = 32,
   localparam int SH_W = $clog2(W)
) (
   input  logic [W-1:0]    data_i,
   input  logic [SH_W-1:0] shamt_i,
   input  logic            is_right_i,
   input  logic            is_arith_i,
   input  logic            is_rotate_i,
   output logic [W-1:0]    data_o
);

   logic [2*W-1:0] dbl;

   always_comb begin
      dbl    = {data_i, data_i};
      data_o = '0;
      if (is_rotate_i) begin
         if (is_right_i) begin
            dbl    = dbl >> shamt_i;
            data_o = dbl[W-1:0];
         end else begin
            dbl    = dbl << shamt_i;
            data_o = dbl[2*W-1:W];
         end
      end else if (is_right_i) begin
         if (is_arith_i) data_o = $unsigned($signed(data_i) >>> shamt_i);
         else            data_o = data_i >> shamt_i;
      end else begin
         data_o = data_i << shamt_i;
      end
   end

endmodule

// File: rtl/bs_unpack.sv
// Bitstream reader: buffers W-bit words and hands out 0..W-bit LSB-first
// fields on request, optionally sign-extended.
module bs_unpack
   import bs_pkg::*;
#(
   parameter int W     = 32,
   parameter int LEN_W = $clog2(W) + 1,
   parameter int CNT_W = $clog2(2 * W) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_vld_i,
   input  logic [W-1:0]     in_data_i,
   output logic             in_rdy_o,
   input  logic             req_vld_i,
   input  logic [LEN_W-1:0] req_len_i,
   input  logic             req_sgn_i,
   output logic             req_rdy_o,
   output logic             rsp_vld_o,
   output logic [W-1:0]     rsp_data_o,
   input  logic             rsp_rdy_i,
   input  logic             flush_i,
   output logic [CNT_W-1:0] level_o
);

   localparam logic [CNT_W-1:0] W_CNT = CNT_W'(W);

   logic [2*W-1:0]   bits_q, bits_d, bits_shr, word_shl;
   logic [CNT_W-1:0] cnt_q, cnt_d, cnt_post, len_c;
   logic             rsp_vld_q, rsp_vld_d;
   logic [W-1:0]     rsp_data_q, rsp_data_d;
   logic             in_fire, req_fire;
   logic [LEN_W-1:0] shamt;
   logic [W-1:0]     keep, field, field_sx;
   logic [MAX_W-1:0] field_ext;

   // Valid/ready: a transfer happens on a clock edge where both are high; the
   // producer holds data stable while valid is high and ready is low.
   assign len_c     = CNT_W'(req_len_i);
   assign in_rdy_o  = (cnt_q <= W_CNT) & ~flush_i;
   assign req_rdy_o = (cnt_q >= len_c) & (~rsp_vld_q | rsp_rdy_i) & ~flush_i;
   assign in_fire   = in_vld_i & in_rdy_o;
   assign req_fire  = req_vld_i & req_rdy_o;
   assign shamt     = req_fire ? req_len_i : '0;

   bs #(.W(2 * W)) u_consume (
      .data_i      (bits_q),
      .shamt_i     (shamt),
      .is_right_i  (1'b1),
      .is_arith_i  (1'b0),
      .is_rotate_i (1'b0),
      .data_o      (bits_shr)
   );

   always_comb begin
      keep      = ~({W{1'b1}} << req_len_i);
      field     = bits_q[W-1:0] & keep;
      field_ext = '0;
      field_ext[W-1:0] = field;
      field_sx  = W'(sext(field_ext, len_t'(req_len_i)));
      cnt_post  = cnt_q - (req_fire ? len_c : '0);
      // Bits above cnt are always zero, so OR places the word at cnt_post.
      word_shl  = {{W{1'b0}}, in_data_i} << cnt_post;

      bits_d = bits_q;
      cnt_d  = cnt_q;
      if (flush_i) begin
         bits_d = '0;
         cnt_d  = '0;
      end else begin
         bits_d = bits_shr;
         cnt_d  = cnt_post;
         if (in_fire) begin
            bits_d = bits_shr | word_shl;
            cnt_d  = cnt_post + W_CNT;
         end
      end

      rsp_vld_d  = rsp_vld_q;
      rsp_data_d = rsp_data_q;
      if (flush_i) begin
         rsp_vld_d = 1'b0;
      end else if (req_fire) begin
         rsp_vld_d  = 1'b1;
         rsp_data_d = req_sgn_i ? field_sx : field;
      end else if (rsp_rdy_i) begin
         rsp_vld_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         bits_q     <= '0;
         cnt_q      <= '0;
         rsp_vld_q  <= 1'b0;
         rsp_data_q <= '0;
      end else begin
         bits_q     <= bits_d;
         cnt_q      <= cnt_d;
         rsp_vld_q  <= rsp_vld_d;
         rsp_data_q <= rsp_data_d;
      end
   end

   assign rsp_vld_o  = rsp_vld_q;
   assign rsp_data_o = rsp_data_q;
   assign level_o    = cnt_q;

   always_ff @(posedge clk) begin
      if (rst_n) begin
         assert (!req_vld_i || (req_len_i <= LEN_W'(W)));
         assert (cnt_t'(cnt_q) <= cnt_t'(2 * W));
         assert (!rsp_vld_q || !$isunknown(rsp_data_q));
      end
   end

endmodule

// File: tb/tb_bs_unpack.sv
// Directed bench for bs_unpack at W=8: hand-computed fields, backpressure,
// full buffer, flush and reset cases.
module tb_bs_unpack;

   localparam int W     = 8;
   localparam int LEN_W = 4;
   localparam int CNT_W = 5;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             in_vld_i;
   logic [W-1:0]     in_data_i;
   logic             in_rdy_o;
   logic             req_vld_i;
   logic [LEN_W-1:0] req_len_i;
   logic             req_sgn_i;
   logic             req_rdy_o;
   logic             rsp_vld_o;
   logic [W-1:0]     rsp_data_o;
   logic             rsp_rdy_i;
   logic             flush_i;
   logic [CNT_W-1:0] level_o;

   int n_vec = 0;
   int n_err = 0;

   bs_unpack #(.W(W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_vld_i   (in_vld_i),
      .in_data_i  (in_data_i),
      .in_rdy_o   (in_rdy_o),
      .req_vld_i  (req_vld_i),
      .req_len_i  (req_len_i),
      .req_sgn_i  (req_sgn_i),
      .req_rdy_o  (req_rdy_o),
      .rsp_vld_o  (rsp_vld_o),
      .rsp_data_o (rsp_data_o),
      .rsp_rdy_i  (rsp_rdy_i),
      .flush_i    (flush_i),
      .level_o    (level_o)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout, expected $finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [W-1:0] d);
      int k;
      k = 0;
      in_vld_i  = 1'b1;
      in_data_i = d;
      @(negedge clk);
      while (!in_rdy_o && k < 20) begin
         k++;
         @(negedge clk);
      end
      chk("push_rdy", 32'(in_rdy_o), 32'd1);
      @(posedge clk);
      #1;
      in_vld_i = 1'b0;
   endtask

   task automatic req(input string tag, input int len, input logic sgn, input logic [W-1:0] exp);
      int k;
      k = 0;
      req_vld_i = 1'b1;
      req_len_i = LEN_W'(len);
      req_sgn_i = sgn;
      @(negedge clk);
      while (!req_rdy_o && k < 20) begin
         k++;
         @(negedge clk);
      end
      chk({tag, "_rdy"}, 32'(req_rdy_o), 32'd1);
      @(posedge clk);
      #1;
      req_vld_i = 1'b0;
      chk({tag, "_vld"}, 32'(rsp_vld_o), 32'd1);
      chk(tag, 32'(rsp_data_o), 32'(exp));
   endtask

   initial begin
      rst_n     = 1'b0;
      in_vld_i  = 1'b0;
      in_data_i = '0;
      req_vld_i = 1'b0;
      req_len_i = '0;
      req_sgn_i = 1'b0;
      rsp_rdy_i = 1'b1;
      flush_i   = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      chk("rst_level", 32'(level_o), 32'd0);
      chk("rst_vld", 32'(rsp_vld_o), 32'd0);
      chk("rst_data", 32'(rsp_data_o), 32'd0);
      chk("rst_in_rdy", 32'(in_rdy_o), 32'd1);

      // Nibble split, plus a zero-length field that must consume nothing.
      push(8'hA5);
      req("t1_len0", 0, 1'b1, 8'h00);
      chk("t1_lvl8", 32'(level_o), 32'd8);
      req("t1_lo", 4, 1'b0, 8'h05);
      req("t1_hi", 4, 1'b0, 8'h0A);
      chk("t1_lvl0", 32'(level_o), 32'd0);

      // Signed fields: full width passes raw, 4-bit 0x8 extends to 0xF8.
      push(8'hF0);
      req("t2_s8", 8, 1'b1, 8'hF0);
      push(8'h08);
      req("t2_s4", 4, 1'b1, 8'hF8);
      req("t2_rest", 4, 1'b0, 8'h00);

      // Field straddling two words.
      push(8'hFF);
      push(8'h01);
      chk("t3_lvl16", 32'(level_o), 32'd16);
      req("t3_f3", 3, 1'b0, 8'h07);
      req("t3_f8", 8, 1'b0, 8'h3F);
      chk("t3_lvl5", 32'(level_o), 32'd5);
      req("t3_drain", 5, 1'b0, 8'h00);

      // Backpressure: first field held while further requests wait.
      push(8'hAB);
      push(8'hCD);
      rsp_rdy_i = 1'b0;
      req_vld_i = 1'b1;
      req_len_i = 4'd4;
      req_sgn_i = 1'b0;
      @(posedge clk);
      #1;
      chk("t4_vld", 32'(rsp_vld_o), 32'd1);
      chk("t4_first", 32'(rsp_data_o), 32'h0B);
      repeat (3) begin
         @(negedge clk);
         chk("t4_stall_rdy", 32'(req_rdy_o), 32'd0);
         chk("t4_hold", 32'(rsp_data_o), 32'h0B);
      end
      @(negedge clk);
      rsp_rdy_i = 1'b1;
      #1;
      chk("t4_release_rdy", 32'(req_rdy_o), 32'd1);
      @(posedge clk);
      #1;
      chk("t4_second", 32'(rsp_data_o), 32'h0A);
      @(posedge clk);
      #1;
      chk("t4_third", 32'(rsp_data_o), 32'h0D);
      req_vld_i = 1'b0;
      @(posedge clk);
      #1;
      chk("t4_idle_vld", 32'(rsp_vld_o), 32'd0);
      chk("t4_lvl4", 32'(level_o), 32'd4);
      req("t4_last", 4, 1'b0, 8'h0C);

      // Full buffer, then request and word offered in the same cycle.
      push(8'h11);
      push(8'h22);
      chk("t5_lvl16", 32'(level_o), 32'd16);
      chk("t5_in_rdy0", 32'(in_rdy_o), 32'd0);
      in_vld_i  = 1'b1;
      in_data_i = 8'h33;
      req_vld_i = 1'b1;
      req_len_i = 4'd8;
      req_sgn_i = 1'b0;
      @(negedge clk);
      chk("t5_in_blocked", 32'(in_rdy_o), 32'd0);
      chk("t5_req_rdy", 32'(req_rdy_o), 32'd1);
      @(posedge clk);
      #1;
      req_vld_i = 1'b0;
      chk("t5_field", 32'(rsp_data_o), 32'h11);
      chk("t5_lvl8", 32'(level_o), 32'd8);
      chk("t5_in_rdy1", 32'(in_rdy_o), 32'd1);
      @(posedge clk);
      #1;
      in_vld_i = 1'b0;
      chk("t5_lvl_refill", 32'(level_o), 32'd16);
      req("t5_w2", 8, 1'b0, 8'h22);
      req("t5_w3", 8, 1'b0, 8'h33);
      chk("t5_lvl0", 32'(level_o), 32'd0);

      // Flush with a held response and a word on offer.
      push(8'h5A);
      rsp_rdy_i = 1'b0;
      req("t6_pre", 4, 1'b0, 8'h0A);
      flush_i   = 1'b1;
      in_vld_i  = 1'b1;
      in_data_i = 8'h77;
      @(negedge clk);
      chk("t6_flush_in_rdy", 32'(in_rdy_o), 32'd0);
      chk("t6_flush_req_rdy", 32'(req_rdy_o), 32'd0);
      @(posedge clk);
      #1;
      flush_i  = 1'b0;
      in_vld_i = 1'b0;
      chk("t6_flush_lvl", 32'(level_o), 32'd0);
      chk("t6_flush_vld", 32'(rsp_vld_o), 32'd0);

      // Reset while a response is pending.
      push(8'h99);
      req("t6_pre_rst", 8, 1'b0, 8'h99);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n     = 1'b1;
      rsp_rdy_i = 1'b1;
      chk("t6_rst_lvl", 32'(level_o), 32'd0);
      chk("t6_rst_vld", 32'(rsp_vld_o), 32'd0);
      chk("t6_rst_data", 32'(rsp_data_o), 32'd0);
      push(8'h3C);
      req("t6_after", 8, 1'b0, 8'h3C);
      chk("t6_end_lvl", 32'(level_o), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
